// File: rtl/baud_autodetect_if.sv
`default_nettype none
// ============================================================================
//  Module      : baud_autodetect_if
//  Description : Register-side bundle of the baud auto-detector. It carries
//                the raw rx line, the CPU control pulses and write data, and
//                the dvsr/status results.
//                master : register interface / CPU side (drives the controls)
//                slave  : baud_autodetect (drives dvsr and status)
//  Revision    : 1.0  initial release
// ============================================================================
interface baud_autodetect_if;
    logic        rx;        // raw serial input, asynchronous to clk
    logic        start;     // arm detection (1-cycle pulse)
    logic        abort;     // cancel detection (1-cycle pulse)
    logic        wr_dvsr;   // load cpu_dvsr into dvsr (1-cycle pulse)
    logic [10:0] cpu_dvsr;  // CPU write data
    logic [10:0] dvsr;      // divisor to the baud generator
    logic        busy;      // detection in progress
    logic        done;      // sticky: last detection succeeded
    logic        err;       // sticky: last detection failed

    modport master (
        output rx, start, abort, wr_dvsr, cpu_dvsr,
        input  dvsr, busy, done, err
    );

    modport slave (
        input  rx, start, abort, wr_dvsr, cpu_dvsr,
        output dvsr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/baud_autodetect.sv
`default_nettype none
// ============================================================================
//  Module      : baud_autodetect
//  Description : Owns the 11-bit dvsr word of the UART baud generator. The
//                CPU can write it directly, or request a measurement from an
//                incoming 0x55 sync character on rx:
//                  dvsr = round(8-bit-time cycle count / 128) - 1
//  Ports       : clk      - system clock, rising edge
//                reset_n  - asynchronous active-low reset
//                bus      - baud_autodetect_if.slave
//                           (rx, start, abort, wr_dvsr, cpu_dvsr in;
//                            dvsr, busy, done, err out)
//  Revision    : 1.0  initial release
// ============================================================================
module baud_autodetect #(
    parameter logic [10:0] DEFAULT_DVSR = 11'd650,
    parameter int          IDLE_CYC     = 1024,
    parameter int          CNT_W        = 19
) (
    input  logic                clk,
    input  logic                reset_n,
    baud_autodetect_if.slave    bus
);

    localparam int IDLE_W = $clog2(IDLE_CYC + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_IDLE = 3'd1;
    localparam logic [2:0] S_WAIT_FALL = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_CALC      = 3'd4;
    localparam logic [2:0] S_ERR       = 3'd5;

    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]    C_ROUND     = (CNT_W+1)'(64);
    localparam logic [CNT_W:0]    C_Q_MIN     = (CNT_W+1)'(2);
    localparam logic [CNT_W:0]    C_Q_MAX     = (CNT_W+1)'(2048);
    localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(IDLE_CYC - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        falls_q, falls_d;
    logic [10:0]       dvsr_q, dvsr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              rx_s;
    logic              fall;
    logic              start_ok;
    logic              cancel;
    logic              last_fall;
    logic [CNT_W:0]    q_sum;
    logic [CNT_W:0]    q;
    logic              q_bad;

    assign rx_s     = rx_s2_q;
    // Both edges see the same synchronizer delay, so the period is exact.
    assign fall     = rx_prev_q & ~rx_s2_q;
    // abort wins over a simultaneous start while idle
    assign start_ok = bus.start & ~bus.abort;
    // A CPU write during detection cancels it exactly like abort.
    assign cancel   = (state_q != S_IDLE) & (bus.abort | bus.wr_dvsr);
    // 0x55 LSB-first falls at start, b1, b3, b5, b7: b7 is the 4th further one.
    assign last_fall = fall & (falls_q == 2'd3);

    // Evaluated one bit wider than the counter so +64 never wraps.
    assign q_sum = {1'b0, cnt_q} + C_ROUND;
    assign q     = q_sum >> 7;
    assign q_bad = (q < C_Q_MIN) | (q > C_Q_MAX);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_ok) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s && (idle_q == C_IDLE_LAST)) state_d = S_WAIT_FALL;
            S_WAIT_FALL: if (fall) state_d = S_MEASURE;
            S_MEASURE: begin
                if (last_fall)               state_d = S_CALC;
                else if (cnt_q == C_CNT_MAX) state_d = S_ERR;
            end
            S_CALC:      state_d = q_bad ? S_ERR : S_IDLE;
            S_ERR:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (cancel) state_d = S_IDLE;
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        idle_d  = idle_q;
        cnt_d   = cnt_q;
        falls_d = falls_q;
        dvsr_d  = dvsr_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idle_d = '0;
                end
            end
            S_WAIT_IDLE: begin
                idle_d = rx_s ? (idle_q + IDLE_W'(1)) : '0;
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    cnt_d   = CNT_W'(1);
                    falls_d = 2'd0;
                end
            end
            S_MEASURE: begin
                // The count freezes on the final edge so CALC sees 8 bit times.
                if (!last_fall && (cnt_q != C_CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
                if (fall && !last_fall) falls_d = falls_q + 2'd1;
            end
            S_CALC: begin
                if (!q_bad) begin
                    dvsr_d = q[10:0] - 11'd1;
                    done_d = 1'b1;
                end
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: ;
        endcase
        // A cancelled detection leaves the visible results untouched.
        if (cancel) begin
            dvsr_d = dvsr_q;
            done_d = done_q;
            err_d  = err_q;
        end
        if (bus.wr_dvsr) dvsr_d = bus.cpu_dvsr;
    end

    // ------------------------------------------------------------------
    // Datapath registers and rx synchronizer (idles high)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            idle_q    <= '0;
            cnt_q     <= '0;
            falls_q   <= '0;
            dvsr_q    <= DEFAULT_DVSR;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_s1_q   <= bus.rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            idle_q    <= idle_d;
            cnt_q     <= cnt_d;
            falls_q   <= falls_d;
            dvsr_q    <= dvsr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.dvsr = dvsr_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_baud_autodetect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_autodetect
//  Description : Self-checking bench for baud_autodetect. A main instance with
//                default parameters covers CPU writes, directed and random
//                sync characters, range limits and cancellation; a second
//                instance with a short counter covers counter saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_baud_autodetect;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    // reference model state (main instance)
    int   exp_dvsr;
    int   exp_done;
    int   exp_err;

    always #5 clk = ~clk;

    baud_autodetect_if bus ();
    baud_autodetect_if bus_s ();

    baud_autodetect dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    baud_autodetect #(
        .DEFAULT_DVSR (11'd100),
        .IDLE_CYC     (16),
        .CNT_W        (12)
    ) dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic cpu_write(input int v);
        bus.cpu_dvsr = 11'(v);
        bus.wr_dvsr  = 1'b1;
        tick(1);
        bus.wr_dvsr  = 1'b0;
    endtask

    // One 8N1 character, LSB first, each level held b cycles.
    task automatic send_char(input logic [7:0] ch, input int b);
        logic [9:0] frame;
        frame = {1'b1, ch, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = frame[i];
            tick(b);
        end
        bus.rx = 1'b1;
    endtask

    task automatic wait_not_busy(input int limit);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
    endtask

    // Expected outcome of measuring a sync character at b cycles per bit.
    function automatic void model_detect(input int b);
        longint cnt, q;
        cnt = 8 * longint'(b);
        q   = (cnt + 64) / 128;
        if (cnt >= (longint'(1) << 19) - 1 || q < 2 || q > 2048) begin
            exp_done = 0;
            exp_err  = 1;
        end else begin
            exp_dvsr = int'(q) - 1;
            exp_done = 1;
            exp_err  = 0;
        end
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_dvsr"}, {21'd0, bus.dvsr}, exp_dvsr);
        chk({tag, "_done"}, {31'd0, bus.done}, exp_done);
        chk({tag, "_err"},  {31'd0, bus.err},  exp_err);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic detect(input string tag, input int b);
        pulse_start();
        tick(1100);
        send_char(8'h55, b);
        tick(4);
        wait_not_busy(50);
        model_detect(b);
        check_state(tag);
    endtask

    initial begin
        int b;
        int n;

        reset_n        = 1'b0;
        bus.rx         = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.wr_dvsr    = 1'b0;
        bus.cpu_dvsr   = '0;
        bus_s.rx       = 1'b1;
        bus_s.start    = 1'b0;
        bus_s.abort    = 1'b0;
        bus_s.wr_dvsr  = 1'b0;
        bus_s.cpu_dvsr = '0;
        exp_dvsr = 650;
        exp_done = 0;
        exp_err  = 0;
        tick(3);
        check_state("reset");
        chk("reset_s_dvsr", {21'd0, bus_s.dvsr}, 32'd100);
        reset_n = 1'b1;
        tick(2);

        // CPU writes, including the accepted value 0
        cpu_write(53);
        exp_dvsr = 53;
        chk("wr53", {21'd0, bus.dvsr}, exp_dvsr);
        cpu_write(0);
        exp_dvsr = 0;
        chk("wr0", {21'd0, bus.dvsr}, exp_dvsr);

        // start together with abort while idle: stays idle
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick(1);
        chk("start_abort_busy", {31'd0, bus.busy}, 32'd0);

        // 115200 baud at 100 MHz
        detect("b868", 868);

        // lower range limit: q=1 fails, q=2 gives dvsr=1; q=0 fails
        detect("b23", 23);
        detect("b24", 24);
        detect("b4", 4);

        // random rates
        for (int i = 0; i < 5; i++) begin
            b = int'($urandom_range(25, 700));
            detect("rand", b);
        end

        // an edge before the line has idled long enough is ignored
        pulse_start();
        tick(500);
        bus.rx = 1'b0;
        tick(60);
        bus.rx = 1'b1;
        tick(1100);
        send_char(8'h55, 100);
        tick(4);
        wait_not_busy(50);
        model_detect(100);
        check_state("short_idle");

        // abort mid-measurement
        pulse_start();
        exp_done = 0;
        exp_err  = 0;
        tick(1100);
        bus.rx = 1'b0;
        tick(50);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        bus.rx = 1'b1;
        check_state("abort");

        // CPU write mid-measurement cancels and loads
        pulse_start();
        tick(1100);
        bus.rx = 1'b0;
        tick(50);
        cpu_write(777);
        bus.rx = 1'b1;
        exp_dvsr = 777;
        check_state("wr_mid");
        tick(20);
        detect("after_wr", 300);

        // counter saturation on the short-counter instance
        bus_s.start = 1'b1;
        tick(1);
        bus_s.start = 1'b0;
        tick(40);
        bus_s.rx = 1'b0;
        n = 0;
        tick(1);
        while (bus_s.busy === 1'b1 && n < 6000) begin
            tick(1);
            n++;
        end
        bus_s.rx = 1'b1;
        chk("ovf_busy", {31'd0, bus_s.busy}, 32'd0);
        chk("ovf_err", {31'd0, bus_s.err}, 32'd1);
        chk("ovf_done", {31'd0, bus_s.done}, 32'd0);
        chk("ovf_dvsr", {21'd0, bus_s.dvsr}, 32'd100);
        chk("ovf_time", {31'd0, (n >= 4085 && n <= 4110)}, 32'd1);

        // asynchronous reset mid-measurement
        pulse_start();
        tick(1100);
        bus.rx = 1'b0;
        tick(30);
        #1 reset_n = 1'b0;
        #1;
        exp_dvsr = 650;
        exp_done = 0;
        exp_err  = 0;
        check_state("rst_mid");
        bus.rx = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
